// File: rtl/uart_word_framer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_word_framer
//  Purpose  : 8N1 UART receiver plus word framer. Serial bytes are packed
//             into a BYTES-wide word. Framing is opened by a run of
//             SYNC_COUNT consecutive SYNC_BYTEs and closed by a word made
//             entirely of IDLE_BYTE. Completed words leave on data_word with
//             a one-cycle word_valid strobe.
//  Options  : `define WORD_TIMEOUT_EN to build the partial-word timeout.
//             Without it, timeout_pulse is constant 0 and a partial word
//             waits indefinitely.
//  Ports    : clk            system clock, rising edge
//             reset          asynchronous, active-low reset
//             uart_rx_pin    UART line, idle high, asynchronous to clk
//             data_word      last completed word, byte 0 in [7:0]
//             word_valid     one-cycle pulse when data_word updates
//             active         high while the framer is in ACTIVE
//             frame_err      one-cycle pulse on a bad stop bit
//             timeout_pulse  one-cycle pulse on partial-word abort
//  Revision : 1.0 - initial release
// ============================================================================
module uart_word_framer #(
    parameter int         CLK_HZ       = 50000000,
    parameter int         BIT_RATE     = 9600,
    parameter int         BYTES        = 8,
    parameter logic [7:0] SYNC_BYTE    = 8'hAA,
    parameter int         SYNC_COUNT   = 8,
    parameter logic [7:0] IDLE_BYTE    = 8'h55,
    parameter int         TIMEOUT_BITS = 40
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               uart_rx_pin,
    output logic [8*BYTES-1:0] data_word,
    output logic               word_valid,
    output logic               active,
    output logic               frame_err,
    output logic               timeout_pulse
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int CPB      = CLK_HZ / BIT_RATE;
    localparam int CNT_W    = $clog2(CPB + 1);
    localparam int BCW      = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TO_LIMIT = TIMEOUT_BITS * CPB;

    localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] HALF_END  = CNT_W'(CPB / 2 - 1);
    localparam logic [BCW-1:0]   LAST_LANE = BCW'(BYTES - 1);
    localparam logic [7:0]       SYNC_LAST = 8'(SYNC_COUNT - 1);

    // ------------------------------------------------------------------------
    // Input synchroniser. rx_prev is one more stage so that a falling edge
    // can be seen on already-synchronised samples.
    // ------------------------------------------------------------------------
    logic rx_meta;
    logic rx_sync;
    logic rx_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx_pin;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // ------------------------------------------------------------------------
    // UART receiver, 8N1. The start bit is re-checked at its midpoint, so
    // every later sample lands in the middle of its bit cell.
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    rx_state_t        rx_state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic [7:0]       rx_byte;
    logic             byte_strobe;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state    <= RX_IDLE;
            clk_cnt     <= '0;
            bit_idx     <= 3'd0;
            shift       <= 8'd0;
            rx_byte     <= 8'd0;
            byte_strobe <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            byte_strobe <= 1'b0;
            frame_err   <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    clk_cnt <= '0;
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (clk_cnt == HALF_END) begin
                        clk_cnt  <= '0;
                        bit_idx  <= 3'd0;
                        // A line already back high is a glitch, not a start.
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt == BIT_END) begin
                        clk_cnt <= '0;
                        shift   <= {rx_sync, shift[7:1]};   // LSB first
                        if (bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt == BIT_END) begin
                        clk_cnt  <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin
                            byte_strobe <= 1'b1;
                            rx_byte     <= shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Assembly register with the incoming byte merged into its lane. Used
    // both to update the register and, on the last lane, as the finished
    // word, so data_word is always loaded in one step.
    // ------------------------------------------------------------------------
    logic [BYTES-1:0][7:0] asm_lanes;
    logic [BYTES-1:0][7:0] next_word;
    logic                  all_idle;

    always_comb begin
        next_word          = asm_lanes;
        next_word[byte_cnt] = rx_byte;
        all_idle           = 1'b1;
        for (int i = 0; i < BYTES; i++) begin
            if (next_word[i] != IDLE_BYTE) begin
                all_idle = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Framer FSM
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        FR_IDLE   = 1'b0,
        FR_ACTIVE = 1'b1
    } fr_state_t;

    fr_state_t      fr_state;
    logic [7:0]     sync_cnt;
    logic [BCW-1:0] byte_cnt;

`ifdef WORD_TIMEOUT_EN
    localparam int           TO_W   = $clog2(TO_LIMIT + 1);
    localparam logic [TO_W-1:0] TO_END = TO_W'(TO_LIMIT - 1);
    logic [TO_W-1:0] to_cnt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fr_state      <= FR_IDLE;
            active        <= 1'b0;
            sync_cnt      <= 8'd0;
            byte_cnt      <= '0;
            asm_lanes     <= '0;
            data_word     <= '0;
            word_valid    <= 1'b0;
`ifdef WORD_TIMEOUT_EN
            to_cnt        <= '0;
            timeout_pulse <= 1'b0;
`endif
        end else begin
            word_valid    <= 1'b0;
`ifdef WORD_TIMEOUT_EN
            timeout_pulse <= 1'b0;
`endif
            case (fr_state)
                FR_IDLE: begin
`ifdef WORD_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    // A corrupted byte breaks the preamble run.
                    if (frame_err) begin
                        sync_cnt <= 8'd0;
                    end else if (byte_strobe) begin
                        if (rx_byte == SYNC_BYTE) begin
                            if (sync_cnt == SYNC_LAST) begin
                                fr_state <= FR_ACTIVE;
                                active   <= 1'b1;
                                sync_cnt <= 8'd0;
                                byte_cnt <= '0;
                            end else begin
                                sync_cnt <= sync_cnt + 1'b1;
                            end
                        end else begin
                            sync_cnt <= 8'd0;
                        end
                    end
                end
                FR_ACTIVE: begin
                    if (byte_strobe) begin
                        asm_lanes <= next_word;
                        if (byte_cnt == LAST_LANE) begin
                            byte_cnt <= '0;
                            if (all_idle) begin
                                fr_state <= FR_IDLE;
                                active   <= 1'b0;
                                sync_cnt <= 8'd0;
                            end else begin
                                data_word  <= next_word;
                                word_valid <= 1'b1;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
`ifdef WORD_TIMEOUT_EN
                    // Runs only while a word is partly assembled; any new
                    // byte restarts the wait.
                    if (byte_strobe || (byte_cnt == '0)) begin
                        to_cnt <= '0;
                    end else if (to_cnt == TO_END) begin
                        to_cnt        <= '0;
                        byte_cnt      <= '0;
                        asm_lanes     <= '0;
                        timeout_pulse <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                default: fr_state <= FR_IDLE;
            endcase
        end
    end

`ifndef WORD_TIMEOUT_EN
    // No timeout hardware: this expression is constant 0 for any legal
    // parameter set.
    assign timeout_pulse = (TO_LIMIT < 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_word_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_word_framer
//  Purpose  : Self-checking bench for uart_word_framer. A byte-level model
//             predicts words, active state, frame errors and timeouts; a
//             compare process checks every word_valid cycle against the
//             predicted word queue. Directed sequences plus random segments.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_word_framer;

    localparam int         CLK_HZ       = 160;
    localparam int         BIT_RATE     = 10;
    localparam int         CPB          = CLK_HZ / BIT_RATE;
    localparam int         BYTES        = 8;
    localparam int         W            = 8 * BYTES;
    localparam logic [7:0] SYNC         = 8'hAA;
    localparam int         SYNC_COUNT   = 8;
    localparam logic [7:0] IDLE         = 8'h55;
    localparam int         TIMEOUT_BITS = 40;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rx = 1'b1;
    logic [W-1:0] data_word;
    logic         word_valid;
    logic         active;
    logic         frame_err;
    logic         timeout_pulse;

    always #5 clk = ~clk;

    uart_word_framer #(
        .CLK_HZ      (CLK_HZ),
        .BIT_RATE    (BIT_RATE),
        .BYTES       (BYTES),
        .SYNC_BYTE   (SYNC),
        .SYNC_COUNT  (SYNC_COUNT),
        .IDLE_BYTE   (IDLE),
        .TIMEOUT_BITS(TIMEOUT_BITS)
    ) dut (
        .clk          (clk),
        .reset        (rst_n),
        .uart_rx_pin  (rx),
        .data_word    (data_word),
        .word_valid   (word_valid),
        .active       (active),
        .frame_err    (frame_err),
        .timeout_pulse(timeout_pulse)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model (byte level) ----------------
    bit           m_active;
    int           m_sync;
    int           m_cnt;
    logic [7:0]   m_lanes [BYTES];
    logic [W-1:0] m_last;
    logic [W-1:0] exp_q [$];
    int           exp_ferr  = 0;
    int           ferr_seen = 0;
    int           exp_to    = 0;
    int           to_seen   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_active = 1'b0;
        m_sync   = 0;
        m_cnt    = 0;
        m_last   = '0;
        for (int i = 0; i < BYTES; i++) m_lanes[i] = 8'h00;
    endfunction

    function automatic void model_byte(input logic [7:0] b, input bit ok);
        logic [W-1:0] w;
        bit           idle_all;
        if (!ok) begin
            exp_ferr++;
            if (!m_active) m_sync = 0;
            return;
        end
        if (!m_active) begin
            if (b == SYNC) begin
                m_sync++;
                if (m_sync == SYNC_COUNT) begin
                    m_active = 1'b1;
                    m_sync   = 0;
                    m_cnt    = 0;
                end
            end else begin
                m_sync = 0;
            end
        end else begin
            m_lanes[m_cnt] = b;
            m_cnt++;
            if (m_cnt == BYTES) begin
                m_cnt    = 0;
                idle_all = 1'b1;
                w        = '0;
                for (int i = 0; i < BYTES; i++) begin
                    w[8*i +: 8] = m_lanes[i];
                    if (m_lanes[i] != IDLE) idle_all = 1'b0;
                end
                if (idle_all) begin
                    m_active = 1'b0;
                    m_sync   = 0;
                end else begin
                    exp_q.push_back(w);
                    m_last = w;
                end
            end
        end
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (word_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word actual=%h required=no word_valid", data_word);
                end else begin
                    logic [W-1:0] w;
                    w = exp_q.pop_front();
                    if (data_word !== w) begin
                        errors++;
                        $display("FAIL word_data actual=%h required=%h", data_word, w);
                    end
                end
            end
            if (frame_err) ferr_seen++;
            if (timeout_pulse) to_seen++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b, input bit ok);
        model_byte(b, ok);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        rx = ok;
        repeat (CPB) @(posedge clk);
        rx = 1'b1;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic silence(input int bits);
`ifdef WORD_TIMEOUT_EN
        if (m_active && (m_cnt != 0) && (bits >= TIMEOUT_BITS + 2)) begin
            m_cnt = 0;
            for (int i = 0; i < BYTES; i++) m_lanes[i] = 8'h00;
            exp_to++;
        end
`endif
        repeat (bits * CPB) @(posedge clk);
    endtask

    task automatic checkpoint(input string tag);
        @(negedge clk);
        check({tag, "_active"}, W'(active), W'(m_active));
        check({tag, "_data_word"}, data_word, m_last);
        check({tag, "_pending_words"}, W'(exp_q.size()), '0);
        check({tag, "_frame_err_count"}, W'(ferr_seen), W'(exp_ferr));
        check({tag, "_timeout_count"}, W'(to_seen), W'(exp_to));
    endtask

    task automatic send_n(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) send_byte(b, 1'b1);
    endtask

    initial begin
        logic [7:0] t1 [8];
        t1 = '{8'hAA, 8'hAA, 8'hFF, 8'hAA, 8'hAA, 8'h00, 8'hAA, 8'hAA};
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {data_word[W-5:0], word_valid, active, frame_err, timeout_pulse}, '0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Preamble and first word
        send_n(SYNC, 8);
        checkpoint("preamble");
        check("preamble_active_lit", W'(active), W'(1));
        for (int i = 0; i < 8; i++) send_byte(t1[i], 1'b1);
        checkpoint("word1");
        check("word1_literal", data_word, 64'hAAAA00AAAAFFAAAA);
        check("model_word1_literal", m_last, 64'hAAAA00AAAAFFAAAA);

        // Idle word closes framing, data_word holds
        send_n(IDLE, 8);
        checkpoint("idle_word");
        check("idle_active_lit", W'(active), W'(0));
        check("idle_hold_literal", data_word, 64'hAAAA00AAAAFFAAAA);

        // Broken preamble
        send_n(SYNC, 7);
        send_byte(8'h01, 1'b1);
        send_n(SYNC, 7);
        checkpoint("broken_pre");
        check("broken_active_lit", W'(active), W'(0));
        send_byte(SYNC, 1'b1);
        checkpoint("pre_complete");
        check("pre_complete_lit", W'(active), W'(1));

        // Frame error does not advance the lane
        send_byte(8'h12, 1'b0);
        checkpoint("ferr");
        check("ferr_count_lit", W'(ferr_seen), W'(1));
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1);
        checkpoint("after_ferr");
        check("after_ferr_literal", data_word, 64'h0807060504030201);

        // Reset mid-word
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #50;
        check("reset_mid_outputs", {data_word[W-5:0], word_valid, active, frame_err, timeout_pulse}, '0);
        #50 rst_n = 1'b1;
        model_reset();
        repeat (4) @(posedge clk);
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1);
        checkpoint("after_reset");
        check("after_reset_active_lit", W'(active), W'(0));
        check("after_reset_word_lit", data_word, '0);

        // Partial word followed by long silence
        send_n(SYNC, 8);
        send_byte(8'hC1, 1'b1);
        send_byte(8'hC2, 1'b1);
        send_byte(8'hC3, 1'b1);
        silence(42);
        checkpoint("silence");
        check("silence_active_lit", W'(active), W'(1));
        for (int i = 1; i <= 8; i++) send_byte(8'hD0 + 8'(i), 1'b1);
        checkpoint("after_silence");
`ifdef WORD_TIMEOUT_EN
        check("timeout_count_lit", W'(to_seen), W'(1));
        check("after_timeout_literal", data_word, 64'hD8D7D6D5D4D3D2D1);
`else
        check("no_timeout_lit", W'(to_seen), W'(0));
        check("no_timeout_literal", data_word, 64'hD5D4D3D2D1C3C2C1);
`endif

        // Randomized segments
        for (int s = 0; s < 16; s++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                send_byte(8'($urandom), 1'b0);
            end else if (r <= 2) begin
                send_n(SYNC, SYNC_COUNT);
            end else if (r == 3) begin
                send_n(IDLE, BYTES);
            end else begin
                for (int k = 0; k < BYTES; k++) begin
                    logic [7:0] b;
                    b = ($urandom_range(0, 4) == 0) ? SYNC : 8'($urandom);
                    send_byte(b, 1'b1);
                end
            end
            checkpoint("random");
        end

        repeat (20) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
